// File: rtl/data_cache_pkg.sv
// data_cache shared definitions: bus widths, geometry defaults and FSM states.
// Optional feature macro: DATA_CACHE_STATS_EN (hit/miss counters on data_cache).
`ifndef DATA_CACHE_DEFINES
`define DATA_CACHE_DEFINES
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define SB_WIDTH   64
`endif

package data_cache_pkg;

    localparam int DC_NLINES     = 4;
    localparam int DC_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        DC_IDLE = 2'd0,
        DC_WB   = 2'd1,
        DC_FILL = 2'd2
    } dc_state_e;

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage for data_cache: one full-line write port and
// a combinational read port, both addressed by line index.
//   clk, reset          : clock, synchronous active-high reset (clears valid/dirty)
//   r_idx_i             : read index; r_tag_o/r_valid_o/r_dirty_o/r_line_o read data
//   we_i, w_idx_i       : write enable and index
//   w_tag_i/w_valid_i/w_dirty_i/w_line_i : full entry written on we_i
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter int NLINES     = DC_NLINES,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    localparam int OFF_W     = $clog2(LINE_WORDS) + 2,
    localparam int IDX_W     = $clog2(NLINES),
    localparam int TAG_W     = `ADDR_WIDTH - IDX_W - OFF_W,
    localparam int LINE_W    = LINE_WORDS * `DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  r_idx_i,
    output logic [TAG_W-1:0]  r_tag_o,
    output logic              r_valid_o,
    output logic              r_dirty_o,
    output logic [LINE_W-1:0] r_line_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  w_idx_i,
    input  logic [TAG_W-1:0]  w_tag_i,
    input  logic              w_valid_i,
    input  logic              w_dirty_i,
    input  logic [LINE_W-1:0] w_line_i
);

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] line_q [NLINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[w_idx_i] <= w_valid_i;
            dirty_q[w_idx_i] <= w_dirty_i;
        end
    end

    // Payload needs no reset: it is only observed through valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[w_idx_i]  <= w_tag_i;
            line_q[w_idx_i] <= w_line_i;
        end
    end

    assign r_tag_o   = tag_q[r_idx_i];
    assign r_valid_o = valid_q[r_idx_i];
    assign r_dirty_o = dirty_q[r_idx_i];
    assign r_line_o  = line_q[r_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache behind store_buffer.
// Ports: clk/reset (sync, active-high); is_load/load_addr -> load_data/stall;
//   sb_valid/sb_data({addr,data}) -> cache_hit (drain accepted);
//   mem_req/mem_we/mem_addr/mem_wdata -> main memory, mem_rdata/mem_ack back.
// DATA_CACHE_STATS_EN adds stat_hits/stat_misses (32-bit wrapping counters).
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NLINES     = DC_NLINES,
    parameter int LINE_WORDS = DC_LINE_WORDS,
    localparam int LINE_W    = LINE_WORDS * 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_load,
    input  logic [`ADDR_WIDTH-1:0] load_addr,
    output logic [`DATA_WIDTH-1:0] load_data,
    output logic                   stall,
    input  logic                   sb_valid,
    input  logic [`SB_WIDTH-1:0]   sb_data,
    output logic                   cache_hit,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [`ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ack
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_misses
`endif
);

    localparam int DW     = `DATA_WIDTH;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NLINES);
    localparam int TAG_W  = `ADDR_WIDTH - IDX_W - OFF_W;

    dc_state_e         state_q, state_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    // Forces one idle mem_req cycle between the WB ack and the FILL request.
    logic              gap_q, gap_d;

    logic [`ADDR_WIDTH-1:0] sb_addr;
    logic [DW-1:0]          sb_wdata;
    logic [`ADDR_WIDTH-1:0] req_addr;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [WORD_W-1:0]      req_word;
    logic                   unused_ok;

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_valid;
    logic              r_dirty;
    logic [LINE_W-1:0] r_line;
    logic [DW-1:0]     r_words [LINE_WORDS];
    logic              hit;

    logic              we;
    logic [TAG_W-1:0]  w_tag;
    logic              w_valid;
    logic              w_dirty;
    logic [LINE_W-1:0] w_line;
    logic [LINE_W-1:0] merged_line;
    logic              hit_inc;
    logic              miss_inc;

    assign sb_addr  = sb_data[`SB_WIDTH-1 -: `ADDR_WIDTH];
    assign sb_wdata = sb_data[DW-1:0];

    // Loads win arbitration; the drain address is looked up only when idle of loads.
    assign req_addr  = is_load ? load_addr : sb_addr;
    assign req_tag   = req_addr[`ADDR_WIDTH-1 -: TAG_W];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_word  = req_addr[2 +: WORD_W];
    assign unused_ok = ^req_addr[1:0];

    // Outside IDLE the array is pinned to the latched miss line.
    assign rd_idx = (state_q == DC_IDLE) ? req_idx : miss_idx_q;
    assign hit    = r_valid && (r_tag == req_tag);

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
        assign r_words[g] = r_line[g*DW +: DW];
    end

    always_comb begin
        merged_line = r_line;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (WORD_W'(w) == req_word) begin
                merged_line[w*DW +: DW] = sb_wdata;
            end
        end
    end

    data_cache_array #(
        .NLINES     (NLINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .r_idx_i   (rd_idx),
        .r_tag_o   (r_tag),
        .r_valid_o (r_valid),
        .r_dirty_o (r_dirty),
        .r_line_o  (r_line),
        .we_i      (we),
        .w_idx_i   (rd_idx),
        .w_tag_i   (w_tag),
        .w_valid_i (w_valid),
        .w_dirty_i (w_dirty),
        .w_line_i  (w_line)
    );

    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        gap_d      = 1'b0;
        stall      = 1'b0;
        cache_hit  = 1'b0;
        load_data  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        we         = 1'b0;
        w_tag      = r_tag;
        w_valid    = r_valid;
        w_dirty    = r_dirty;
        w_line     = r_line;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;

        unique case (state_q)
            DC_IDLE: begin
                if (is_load && hit) begin
                    load_data = r_words[req_word];
                    hit_inc   = 1'b1;
                end else if (!is_load && sb_valid && hit) begin
                    cache_hit = 1'b1;
                    we        = 1'b1;
                    w_dirty   = 1'b1;
                    w_line    = merged_line;
                    hit_inc   = 1'b1;
                end else if (is_load || sb_valid) begin
                    stall      = is_load;
                    miss_inc   = 1'b1;
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    state_d    = (r_valid && r_dirty) ? DC_WB : DC_FILL;
                end
            end
            DC_WB: begin
                stall     = is_load;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag, miss_idx_q, {OFF_W{1'b0}}};
                mem_wdata = r_line;
                if (mem_ack) begin
                    we      = 1'b1;
                    w_dirty = 1'b0;
                    gap_d   = 1'b1;
                    state_d = DC_FILL;
                end
            end
            DC_FILL: begin
                stall    = is_load;
                mem_req  = !gap_q;
                mem_addr = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                if (mem_ack && !gap_q) begin
                    we      = 1'b1;
                    w_tag   = miss_tag_q;
                    w_valid = 1'b1;
                    w_dirty = 1'b0;
                    w_line  = mem_rdata;
                    state_d = DC_IDLE;
                end
            end
            default: begin
                state_d = DC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DC_IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            gap_q      <= gap_d;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_q + {31'd0, hit_inc};
            misses_q <= misses_q + {31'd0, miss_inc};
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule
